// File: rtl/cv32e40p_obi_resp_pkg.sv
// Shared types and constants for the OBI data-side responder.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package cv32e40p_obi_resp_pkg;

  // Deepest response pipe any instance may be configured with.
  localparam int MAX_LATENCY = 8;

  // Width of the outstanding-transaction counter (holds up to MAX_LATENCY+1).
  localparam int CNT_W = 4;

  // One response slot as it travels down the latency pipe.
  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] rdata;
  } obi_resp_t;

endpackage

// File: rtl/cv32e40p_obi_sram.sv
// Single-port word array with per-byte write enables and a registered read port.
// Latency: read data registered on the access edge; a write returns zero data.
// Backpressure: none; an access is performed on every cycle req_i is high.
module cv32e40p_obi_sram
  import cv32e40p_obi_resp_pkg::*;
#(
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [3:0]            be_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [31:0]           wdata_i,
  output logic [31:0]           rdata_o
);

  logic [31:0] mem_q [2**ADDR_WIDTH];
  logic [31:0] rdata_q;

  // Byte-masked write; contents are deliberately left out of reset.
  always_ff @(posedge clk_i) begin
    if (req_i && we_i) begin
      for (int i = 0; i < 4; i++) begin
        if (be_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
  end

  // Read register: captures the word on a read, zero on a write, holds when idle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= 32'h0;
    end else if (req_i) begin
      rdata_q <= we_i ? 32'h0 : mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/cv32e40p_obi_data_responder.sv
// OBI data-side responder: serves core reads/byte-enabled writes from a local SRAM.
// Latency: rvalid exactly RVALID_LATENCY cycles after the granting edge, in order.
// Backpressure: grant withheld by stall_i or when MAX_OUTSTANDING responses are pending
// (registered count). Optional CV32E40P_OBI_DATA_ERR_EN adds data_err_o for
// out-of-range addresses; without it addresses wrap modulo the memory size.
module cv32e40p_obi_data_responder
  import cv32e40p_obi_resp_pkg::*;
#(
  parameter int ADDR_WIDTH      = 14,
  parameter int RVALID_LATENCY  = 1,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             data_req_i,
  output logic             data_gnt_o,
  input  logic             data_we_i,
  input  logic [3:0]       data_be_i,
  input  logic [31:0]      data_addr_i,
  input  logic [31:0]      data_wdata_i,
  output logic             data_rvalid_o,
  output logic [31:0]      data_rdata_o,
`ifdef CV32E40P_OBI_DATA_ERR_EN
  output logic             data_err_o,
`endif
  input  logic             stall_i,
  output logic [CNT_W-1:0] outstanding_o
);

  logic             accept;
  logic             oor;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             s0_vld_q, s0_err_q;
  logic [31:0]      sram_rdata;
  obi_resp_t        s0;
  obi_resp_t        rsp;

  // Grant looks only at the registered count, so a slot freed by this cycle's
  // rvalid becomes usable one cycle later.
  assign data_gnt_o = data_req_i & ~stall_i & (cnt_q < CNT_W'(MAX_OUTSTANDING));
  assign accept     = data_req_i & data_gnt_o;

`ifdef CV32E40P_OBI_DATA_ERR_EN
  logic unused_addr_bits;
  assign oor              = |data_addr_i[31:ADDR_WIDTH+2];
  assign unused_addr_bits = ^data_addr_i[1:0];
`else
  logic unused_addr_bits;
  assign oor              = 1'b0;
  assign unused_addr_bits = ^{data_addr_i[31:ADDR_WIDTH+2], data_addr_i[1:0], rsp.err};
`endif

  // An out-of-range access is turned into a write with no byte enables: memory
  // is untouched and the read register yields the zero data the error needs.
  cv32e40p_obi_sram #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_sram (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .req_i   (accept),
    .we_i    (data_we_i | oor),
    .be_i    (oor ? 4'h0 : data_be_i),
    .addr_i  (data_addr_i[ADDR_WIDTH+1:2]),
    .wdata_i (data_wdata_i),
    .rdata_o (sram_rdata)
  );

  // Stage 0 control bits; its data half is the SRAM read register itself.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s0_vld_q <= 1'b0;
      s0_err_q <= 1'b0;
    end else begin
      s0_vld_q <= accept;
      s0_err_q <= accept & oor;
    end
  end

  assign s0 = {s0_vld_q, s0_err_q, sram_rdata};

  if (RVALID_LATENCY == 1) begin : g_lat1
    assign rsp = s0;
  end else begin : g_pipe
    obi_resp_t pipe_q [RVALID_LATENCY-1];

    // Remaining delay stages; reset drops every in-flight response.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int i = 0; i < RVALID_LATENCY-1; i++) pipe_q[i] <= '0;
      end else begin
        pipe_q[0] <= s0;
        for (int i = 1; i < RVALID_LATENCY-1; i++) pipe_q[i] <= pipe_q[i-1];
      end
    end

    assign rsp = pipe_q[RVALID_LATENCY-2];
  end

  assign data_rvalid_o = rsp.valid;
  assign data_rdata_o  = rsp.rdata;
`ifdef CV32E40P_OBI_DATA_ERR_EN
  assign data_err_o    = rsp.err;
`endif

  // Outstanding count: up on acceptance, down on each delivered response.
  always_comb begin
    cnt_d = cnt_q;
    cnt_d = cnt_d + CNT_W'(accept) - CNT_W'(data_rvalid_o);
  end

  // Outstanding count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign outstanding_o = cnt_q;

endmodule

// File: tb/tb_cv32e40p_obi_data_responder.sv
// Directed bench: latency-1 and latency-3 responders sharing clock and reset.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
// Expected values are hand-computed constants in each step.
module tb_cv32e40p_obi_data_responder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Latency-1 instance
  logic        a_req = 0, a_we = 0, a_stall = 0;
  logic [3:0]  a_be = 0;
  logic [31:0] a_addr = 0, a_wdata = 0;
  logic        a_gnt, a_rvalid;
  logic [31:0] a_rdata;
  logic [3:0]  a_out;
  // Latency-3 instance
  logic        b_req = 0, b_we = 0, b_stall = 0;
  logic [3:0]  b_be = 0;
  logic [31:0] b_addr = 0, b_wdata = 0;
  logic        b_gnt, b_rvalid;
  logic [31:0] b_rdata;
  logic [3:0]  b_out;
`ifdef CV32E40P_OBI_DATA_ERR_EN
  logic        a_err, b_err;
`endif

  cv32e40p_obi_data_responder #(
    .ADDR_WIDTH(14), .RVALID_LATENCY(1), .MAX_OUTSTANDING(2)
  ) dut1 (
    .clk_i(clk), .rst_ni(rst_n),
    .data_req_i(a_req), .data_gnt_o(a_gnt), .data_we_i(a_we), .data_be_i(a_be),
    .data_addr_i(a_addr), .data_wdata_i(a_wdata),
    .data_rvalid_o(a_rvalid), .data_rdata_o(a_rdata),
`ifdef CV32E40P_OBI_DATA_ERR_EN
    .data_err_o(a_err),
`endif
    .stall_i(a_stall), .outstanding_o(a_out)
  );

  cv32e40p_obi_data_responder #(
    .ADDR_WIDTH(14), .RVALID_LATENCY(3), .MAX_OUTSTANDING(2)
  ) dut3 (
    .clk_i(clk), .rst_ni(rst_n),
    .data_req_i(b_req), .data_gnt_o(b_gnt), .data_we_i(b_we), .data_be_i(b_be),
    .data_addr_i(b_addr), .data_wdata_i(b_wdata),
    .data_rvalid_o(b_rvalid), .data_rdata_o(b_rdata),
`ifdef CV32E40P_OBI_DATA_ERR_EN
    .data_err_o(b_err),
`endif
    .stall_i(b_stall), .outstanding_o(b_out)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic a_drive(input logic req, input logic we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wdata);
    a_req = req; a_we = we; a_be = be; a_addr = addr; a_wdata = wdata;
  endtask

  task automatic b_drive(input logic req, input logic we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wdata);
    b_req = req; b_we = we; b_be = be; b_addr = addr; b_wdata = wdata;
  endtask

  // Holds a request on dut3 until granted (bounded), then drops it.
  task automatic b_xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    logic granted;
    granted = 1'b0;
    b_drive(1'b1, we, 4'hF, addr, wdata);
    for (int i = 0; i < 20; i++) begin
      smp();
      if (b_gnt) begin
        granted = 1'b1;
        break;
      end
      nxt();
    end
    chk("b_xfer_gnt", {31'h0, granted}, 32'h1);
    nxt();
    b_drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [9:0]  exp_g;
    logic [9:0]  exp_v;
    int          k, r;
    logic [3:0]  peak;
    logic [31:0] w0_exp;

    // ---- reset state
    repeat (3) nxt();
    smp();
    chk("rst_a_rvalid", {31'h0, a_rvalid}, 32'h0);
    chk("rst_a_rdata", a_rdata, 32'h0);
    chk("rst_a_out", {28'h0, a_out}, 32'h0);
    chk("rst_b_rvalid", {31'h0, b_rvalid}, 32'h0);
    chk("rst_b_out", {28'h0, b_out}, 32'h0);
    nxt();
    rst_n = 1'b1;

    // ---- 1: full write then read, latency 1
    nxt(); a_drive(1, 1, 4'hF, 32'h100, 32'hDEADBEEF); smp();
    chk("t1_wr_gnt", {31'h0, a_gnt}, 32'h1);
    chk("t1_wr_rv_before", {31'h0, a_rvalid}, 32'h0);
    nxt(); a_drive(1, 0, 4'hF, 32'h100, 32'h0); smp();
    chk("t1_rd_gnt", {31'h0, a_gnt}, 32'h1);
    chk("t1_wr_rvalid", {31'h0, a_rvalid}, 32'h1);
    chk("t1_wr_rdata", a_rdata, 32'h0);
    chk("t1_out", {28'h0, a_out}, 32'h1);
    nxt(); a_drive(0, 0, 4'h0, 32'h0, 32'h0); smp();
    chk("t1_rd_rvalid", {31'h0, a_rvalid}, 32'h1);
    chk("t1_rd_rdata", a_rdata, 32'hDEADBEEF);
    nxt(); smp();
    chk("t1_idle_rvalid", {31'h0, a_rvalid}, 32'h0);
    chk("t1_idle_out", {28'h0, a_out}, 32'h0);

    // ---- 2: byte-lane writes and ignored addr[1:0]
    nxt(); a_drive(1, 1, 4'b0001, 32'h100, 32'h000000AA); smp();
    chk("t2_wr_gnt", {31'h0, a_gnt}, 32'h1);
    nxt(); a_drive(1, 0, 4'hF, 32'h100, 32'h0); smp();
    chk("t2_wr_rdata", a_rdata, 32'h0);
    nxt(); a_drive(0, 0, 4'h0, 32'h0, 32'h0); smp();
    chk("t2_rd_rvalid", {31'h0, a_rvalid}, 32'h1);
    chk("t2_rd_rdata", a_rdata, 32'hDEADBEAA);
    nxt(); a_drive(1, 1, 4'hF, 32'h104, 32'h11223344);
    nxt(); a_drive(1, 1, 4'b0110, 32'h104, 32'hAABBCCDD);
    nxt(); a_drive(1, 0, 4'h0, 32'h107, 32'h0);
    nxt(); a_drive(0, 0, 4'h0, 32'h0, 32'h0); smp();
    chk("t2_mid_lanes", a_rdata, 32'h11BBCC44);

    // ---- 4: stall suppresses grant
    nxt(); a_stall = 1'b1; a_drive(1, 0, 4'hF, 32'h100, 32'h0);
    for (int c = 0; c < 5; c++) begin
      smp();
      chk("t4_stall_gnt", {31'h0, a_gnt}, 32'h0);
      chk("t4_stall_rvalid", {31'h0, a_rvalid}, 32'h0);
      nxt();
    end
    a_stall = 1'b0; smp();
    chk("t4_release_gnt", {31'h0, a_gnt}, 32'h1);
    nxt(); a_drive(0, 0, 4'h0, 32'h0, 32'h0); smp();
    chk("t4_rvalid", {31'h0, a_rvalid}, 32'h1);
    chk("t4_rdata", a_rdata, 32'hDEADBEAA);

    // ---- 3: latency 3, two outstanding, req held for 4 reads
    for (int i = 0; i < 4; i++) b_xfer(1'b1, 32'(i*4), 32'hC0DE0000 + 32'(i));
    repeat (5) nxt();
    smp();
    chk("t3_drained_out", {28'h0, b_out}, 32'h0);
    nxt();
    exp_g = 10'b00_0011_0011;
    exp_v = 10'b01_1001_1000;
    k = 0; r = 0; peak = 4'h0;
    for (int c = 0; c < 10; c++) begin
      b_drive(k < 4, 1'b0, 4'hF, 32'(k*4), 32'h0);
      smp();
      if (b_out > peak) peak = b_out;
      chk($sformatf("t3_gnt_c%0d", c), {31'h0, b_gnt}, {31'h0, exp_g[c]});
      chk($sformatf("t3_rvalid_c%0d", c), {31'h0, b_rvalid}, {31'h0, exp_v[c]});
      if (b_rvalid) begin
        chk($sformatf("t3_rdata_%0d", r), b_rdata, 32'hC0DE0000 + 32'(r));
        r++;
      end
      if (b_gnt) k++;
      nxt();
    end
    chk("t3_resp_count", 32'(r), 32'd4);
    chk("t3_peak_out", {28'h0, peak}, 32'h2);
    smp();
    chk("t3_final_out", {28'h0, b_out}, 32'h0);

    // ---- 5: reset with two reads in flight
    nxt(); b_drive(1, 0, 4'hF, 32'h0, 32'h0); smp();
    chk("t5_gnt0", {31'h0, b_gnt}, 32'h1);
    nxt(); b_drive(1, 0, 4'hF, 32'h4, 32'h0); smp();
    chk("t5_gnt1", {31'h0, b_gnt}, 32'h1);
    nxt(); b_drive(0, 0, 4'h0, 32'h0, 32'h0); rst_n = 1'b0; smp();
    chk("t5_rst_out", {28'h0, b_out}, 32'h0);
    chk("t5_rst_rvalid", {31'h0, b_rvalid}, 32'h0);
    nxt(); rst_n = 1'b1; b_drive(1, 0, 4'hF, 32'h8, 32'h0); smp();
    chk("t5_post_gnt", {31'h0, b_gnt}, 32'h1);
    chk("t5_post_rvalid", {31'h0, b_rvalid}, 32'h0);
    nxt(); b_drive(0, 0, 4'h0, 32'h0, 32'h0);
    for (int j = 1; j <= 4; j++) begin
      smp();
      chk($sformatf("t5_rvalid_j%0d", j), {31'h0, b_rvalid}, (j == 3) ? 32'h1 : 32'h0);
      if (b_rvalid) chk("t5_rdata", b_rdata, 32'hC0DE0002);
      nxt();
    end

    // ---- 6: out-of-range address
    a_drive(1, 1, 4'hF, 32'h0, 32'h0BADF00D);
    nxt(); a_drive(1, 0, 4'hF, 32'h8000_0000, 32'h0); smp();
    chk("t6_oor_gnt", {31'h0, a_gnt}, 32'h1);
    nxt(); a_drive(1, 0, 4'hF, 32'h0, 32'h0); smp();
    chk("t6_oor_rvalid", {31'h0, a_rvalid}, 32'h1);
`ifdef CV32E40P_OBI_DATA_ERR_EN
    w0_exp = 32'h0;
    chk("t6_oor_err", {31'h0, a_err}, 32'h1);
`else
    w0_exp = 32'h0BADF00D;
`endif
    chk("t6_oor_rdata", a_rdata, w0_exp);
    nxt(); a_drive(0, 0, 4'h0, 32'h0, 32'h0); smp();
    chk("t6_w0_rvalid", {31'h0, a_rvalid}, 32'h1);
    chk("t6_w0_rdata", a_rdata, 32'h0BADF00D);
`ifdef CV32E40P_OBI_DATA_ERR_EN
    chk("t6_w0_err", {31'h0, a_err}, 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
